// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file and its write scoreboard.
package rf_pkg;
  localparam int REG_ZERO       = 0;
  localparam int REG_SP         = 29;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/register_scoreboard.sv
// Per-register in-flight write counters; Busy is combinational from the counters, counters update on clk.
// Overflow/underflow leave the counter untouched and set a sticky error cleared only by reset.
module register_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int MAX_INFLIGHT = 3,
  parameter int BYPASS_EN    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_inc_vld,
  input  logic [ADDR_WIDTH-1:0] i_inc_idx,
  input  logic                  i_dec_vld,
  input  logic [ADDR_WIDTH-1:0] i_dec_idx,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx1,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx2,
  output logic                  o_busy1,
  output logic                  o_busy2,
  output logic                  o_err
);
  localparam int            DEPTH   = 1 << ADDR_WIDTH;
  localparam int            CW      = clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] r_cnt [DEPTH];
  logic          r_err;
  logic          w_inc, w_dec, w_same, w_fwd1, w_fwd2;

  assign w_inc  = i_inc_vld && (i_inc_idx != ADDR_WIDTH'(REG_ZERO));
  assign w_dec  = i_dec_vld && (i_dec_idx != ADDR_WIDTH'(REG_ZERO));
  assign w_same = w_inc && w_dec && (i_inc_idx == i_dec_idx);

  // The last outstanding write retiring now is being forwarded, so the reader need not stall.
  assign w_fwd1 = (BYPASS_EN != 0) && w_dec && (i_dec_idx == i_rd_idx1) && (r_cnt[i_rd_idx1] == CNT_ONE);
  assign w_fwd2 = (BYPASS_EN != 0) && w_dec && (i_dec_idx == i_rd_idx2) && (r_cnt[i_rd_idx2] == CNT_ONE);

  assign o_busy1 = (r_cnt[i_rd_idx1] != '0) && !w_fwd1;
  assign o_busy2 = (r_cnt[i_rd_idx2] != '0) && !w_fwd2;
  assign o_err   = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_inc && !w_same) begin
        if (r_cnt[i_inc_idx] == CNT_MAX) r_err <= 1'b1;
        else                             r_cnt[i_inc_idx] <= r_cnt[i_inc_idx] + CNT_ONE;
      end
      if (w_dec && !w_same) begin
        if (r_cnt[i_dec_idx] == '0) r_err <= 1'b1;
        else                        r_cnt[i_dec_idx] <= r_cnt[i_dec_idx] - CNT_ONE;
      end
    end
  end
endmodule

// File: rtl/pipelined_register_file.sv
// Register file with two zero-latency read ports, one clocked write port, optional WB->ID bypass
// and an in-flight write scoreboard that drives the ID stall (Busy) outputs.
module pipelined_register_file
  import rf_pkg::*;
#(
  parameter int          DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int          ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int          SP_INDEX     = REG_SP,
  parameter logic [31:0] SP_RESET     = 32'h0000_1FFC,
  parameter int          BYPASS_EN    = 1,
  parameter int          MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  IssueValid,
  input  logic [ADDR_WIDTH-1:0] IssueRegister,
  output logic                  Busy1,
  output logic                  Busy2,
  output logic                  ScoreboardError
);
  localparam int                  DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SP_VAL = DATA_WIDTH'(SP_RESET);

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic                  w_wr_en, w_byp1, w_byp2;

  assign w_wr_en = RegWrite && (WriteRegister != ADDR_WIDTH'(REG_ZERO));
  assign w_byp1  = (BYPASS_EN != 0) && w_wr_en && (WriteRegister == ReadRegister1);
  assign w_byp2  = (BYPASS_EN != 0) && w_wr_en && (WriteRegister == ReadRegister2);

  assign ReadData1 = w_byp1 ? WriteData : r_regs[ReadRegister1];
  assign ReadData2 = w_byp2 ? WriteData : r_regs[ReadRegister2];

  // Entry 0 is only ever loaded by reset, so it reads as zero without a read-side mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= (i == SP_INDEX && i != REG_ZERO) ? SP_VAL : '0;
    end else if (w_wr_en) begin
      r_regs[WriteRegister] <= WriteData;
    end
  end

  register_scoreboard #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .BYPASS_EN   (BYPASS_EN)
  ) u_scoreboard (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_inc_vld(IssueValid),
    .i_inc_idx(IssueRegister),
    .i_dec_vld(RegWrite),
    .i_dec_idx(WriteRegister),
    .i_rd_idx1(ReadRegister1),
    .i_rd_idx2(ReadRegister2),
    .o_busy1  (Busy1),
    .o_busy2  (Busy2),
    .o_err    (ScoreboardError)
  );
endmodule

// File: tb/tb_pipelined_register_file.sv
// Bench for pipelined_register_file: directed vector table, mid-stream reset sequence, then
// random traffic against a count/array reference model, on a bypass and a non-bypass instance.
module tb_pipelined_register_file;
  localparam int MAXI = 3;

  logic        clk, reset;
  logic        we, iv;
  logic [4:0]  wr, rr1, rr2, ir;
  logic [31:0] wd;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        b1, b2, err, b1_nb, b2_nb, err_nb;

  int n_chk = 0;
  int n_err = 0;

  pipelined_register_file dut (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wr), .WriteData(wd),
    .ReadRegister1(rr1), .ReadRegister2(rr2), .ReadData1(rd1), .ReadData2(rd2),
    .IssueValid(iv), .IssueRegister(ir), .Busy1(b1), .Busy2(b2), .ScoreboardError(err)
  );

  pipelined_register_file #(.BYPASS_EN(0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wr), .WriteData(wd),
    .ReadRegister1(rr1), .ReadRegister2(rr2), .ReadData1(rd1_nb), .ReadData2(rd2_nb),
    .IssueValid(iv), .IssueRegister(ir), .Busy1(b1_nb), .Busy2(b2_nb), .ScoreboardError(err_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rr1, rr2;
    logic        iv;
    logic [4:0]  ir;
    logic [31:0] e_rd1, e_rd2;
    logic        e_b1, e_b2, e_err;
    logic [31:0] e_rd1_nb;
    logic        e_b1_nb;
  } vec_t;

  function automatic vec_t mk(input int w, input int a, input logic [31:0] d, input int r1, input int r2,
                              input int i, input int ia, input logic [31:0] x1, input logic [31:0] x2,
                              input int xb1, input int xb2, input int xe, input logic [31:0] n1, input int nb1);
    vec_t v;
    v.we = (w != 0);   v.wr = 5'(a);  v.wd = d;
    v.rr1 = 5'(r1);    v.rr2 = 5'(r2);
    v.iv = (i != 0);   v.ir = 5'(ia);
    v.e_rd1 = x1;      v.e_rd2 = x2;
    v.e_b1 = (xb1 != 0); v.e_b2 = (xb2 != 0); v.e_err = (xe != 0);
    v.e_rd1_nb = n1;   v.e_b1_nb = (nb1 != 0);
    return v;
  endfunction

  localparam int NV = 27;
  vec_t vt [NV];

  // ---------------- reference model ----------------
  logic [31:0] mreg [32];
  int          mcnt [32];
  bit          merr;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i] = 32'h0;
      mcnt[i] = 0;
    end
    mreg[29] = 32'h0000_1FFC;
    merr = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r, input bit byp);
    if (r == 5'd0) return 32'h0;
    if (byp && we && wr == r) return wd;
    return mreg[r];
  endfunction

  // Busy means a write is still owed once any value forwarded this cycle is accounted for.
  function automatic bit m_busy(input logic [4:0] r, input bit byp);
    int owed;
    owed = mcnt[r];
    if (byp && we && wr == r && r != 5'd0) owed = owed - 1;
    return owed > 0;
  endfunction

  task automatic m_step();
    bit inc, dec;
    inc = iv && ir != 5'd0;
    dec = we && wr != 5'd0;
    if (dec) mreg[wr] = wd;
    if (!(inc && dec && ir == wr)) begin
      if (inc) begin
        if (mcnt[ir] == MAXI) merr = 1'b1;
        else mcnt[ir] = mcnt[ir] + 1;
      end
      if (dec) begin
        if (mcnt[wr] == 0) merr = 1'b1;
        else mcnt[wr] = mcnt[wr] - 1;
      end
    end
  endtask

  function automatic logic [4:0] pick();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd29 : 5'(r);
  endfunction

  task automatic check_model(input int c);
    chk($sformatf("r%0d.rd1", c), rd1, m_read(rr1, 1'b1));
    chk($sformatf("r%0d.rd2", c), rd2, m_read(rr2, 1'b1));
    chk($sformatf("r%0d.b1", c), {31'h0, b1}, {31'h0, m_busy(rr1, 1'b1)});
    chk($sformatf("r%0d.b2", c), {31'h0, b2}, {31'h0, m_busy(rr2, 1'b1)});
    chk($sformatf("r%0d.err", c), {31'h0, err}, {31'h0, merr});
    chk($sformatf("r%0d.nb_rd1", c), rd1_nb, m_read(rr1, 1'b0));
    chk($sformatf("r%0d.nb_rd2", c), rd2_nb, m_read(rr2, 1'b0));
    chk($sformatf("r%0d.nb_b1", c), {31'h0, b1_nb}, {31'h0, m_busy(rr1, 1'b0)});
    chk($sformatf("r%0d.nb_b2", c), {31'h0, b2_nb}, {31'h0, m_busy(rr2, 1'b0)});
    chk($sformatf("r%0d.nb_err", c), {31'h0, err_nb}, {31'h0, merr});
  endtask

  initial begin
    //           we wr wd            rr1 rr2 iv ir  rd1           rd2           b1 b2 er rd1_nb        b1nb
    vt[0]  = mk(0, 0, 32'h0,         29, 5,  0, 0,  32'h1FFC,     32'h0,        0, 0, 0, 32'h1FFC,     0);
    vt[1]  = mk(1, 0, 32'hDEADBEEF,  0,  0,  0, 0,  32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    vt[2]  = mk(0, 0, 32'h0,         0,  0,  1, 0,  32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    vt[3]  = mk(0, 0, 32'h0,         0,  0,  0, 0,  32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    vt[4]  = mk(0, 0, 32'h0,         8,  8,  1, 8,  32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    vt[5]  = mk(1, 8, 32'h1234,      8,  8,  0, 0,  32'h1234,     32'h1234,     0, 0, 0, 32'h0,        1);
    vt[6]  = mk(0, 0, 32'h0,         8,  29, 0, 0,  32'h1234,     32'h1FFC,     0, 0, 0, 32'h1234,     0);
    vt[7]  = mk(0, 0, 32'h0,         9,  0,  1, 9,  32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    vt[8]  = mk(0, 0, 32'h0,         9,  0,  1, 9,  32'h0,        32'h0,        1, 0, 0, 32'h0,        1);
    vt[9]  = mk(0, 0, 32'h0,         9,  9,  0, 0,  32'h0,        32'h0,        1, 1, 0, 32'h0,        1);
    vt[10] = mk(1, 9, 32'hAAAA0001,  9,  0,  0, 0,  32'hAAAA0001, 32'h0,        1, 0, 0, 32'h0,        1);
    vt[11] = mk(1, 9, 32'hAAAA0002,  9,  8,  0, 0,  32'hAAAA0002, 32'h1234,     0, 0, 0, 32'hAAAA0001, 1);
    vt[12] = mk(0, 0, 32'h0,         9,  0,  0, 0,  32'hAAAA0002, 32'h0,        0, 0, 0, 32'hAAAA0002, 0);
    vt[13] = mk(0, 0, 32'h0,         12, 12, 1, 12, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    vt[14] = mk(1, 12, 32'h55,       12, 12, 1, 12, 32'h55,       32'h55,       0, 0, 0, 32'h0,        1);
    vt[15] = mk(0, 0, 32'h0,         12, 12, 0, 0,  32'h55,       32'h55,       1, 1, 0, 32'h55,       1);
    vt[16] = mk(0, 0, 32'h0,         10, 0,  1, 10, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    vt[17] = mk(0, 0, 32'h0,         10, 0,  1, 10, 32'h0,        32'h0,        1, 0, 0, 32'h0,        1);
    vt[18] = mk(0, 0, 32'h0,         10, 0,  1, 10, 32'h0,        32'h0,        1, 0, 0, 32'h0,        1);
    vt[19] = mk(0, 0, 32'h0,         10, 0,  1, 10, 32'h0,        32'h0,        1, 0, 0, 32'h0,        1);
    vt[20] = mk(0, 0, 32'h0,         10, 11, 0, 0,  32'h0,        32'h0,        1, 0, 1, 32'h0,        1);
    vt[21] = mk(1, 11, 32'h77,       11, 10, 0, 0,  32'h77,       32'h0,        0, 1, 1, 32'h0,        0);
    vt[22] = mk(0, 0, 32'h0,         11, 10, 0, 0,  32'h77,       32'h0,        0, 1, 1, 32'h77,       0);
    vt[23] = mk(1, 10, 32'h1,        10, 0,  0, 0,  32'h1,        32'h0,        1, 0, 1, 32'h0,        1);
    vt[24] = mk(1, 10, 32'h2,        10, 0,  0, 0,  32'h2,        32'h0,        1, 0, 1, 32'h1,        1);
    vt[25] = mk(1, 10, 32'h3,        10, 0,  0, 0,  32'h3,        32'h0,        0, 0, 1, 32'h2,        1);
    vt[26] = mk(0, 0, 32'h0,         10, 0,  0, 0,  32'h3,        32'h0,        0, 0, 1, 32'h3,        0);

    reset = 1'b1; we = 1'b0; wr = '0; wd = '0; rr1 = 5'd29; rr2 = 5'd5; iv = 1'b0; ir = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.rd1", rd1, 32'h1FFC);
    chk("rst.rd2", rd2, 32'h0);
    chk("rst.busy", {30'h0, b1, b2}, 32'h0);
    chk("rst.err", {30'h0, err, err_nb}, 32'h0);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      we = vt[k].we; wr = vt[k].wr; wd = vt[k].wd; rr1 = vt[k].rr1; rr2 = vt[k].rr2;
      iv = vt[k].iv; ir = vt[k].ir;
      #2;
      chk($sformatf("v%0d.rd1", k), rd1, vt[k].e_rd1);
      chk($sformatf("v%0d.rd2", k), rd2, vt[k].e_rd2);
      chk($sformatf("v%0d.b1", k), {31'h0, b1}, {31'h0, vt[k].e_b1});
      chk($sformatf("v%0d.b2", k), {31'h0, b2}, {31'h0, vt[k].e_b2});
      chk($sformatf("v%0d.err", k), {31'h0, err}, {31'h0, vt[k].e_err});
      chk($sformatf("v%0d.nb_rd1", k), rd1_nb, vt[k].e_rd1_nb);
      chk($sformatf("v%0d.nb_b1", k), {31'h0, b1_nb}, {31'h0, vt[k].e_b1_nb});
      chk($sformatf("v%0d.nb_err", k), {31'h0, err_nb}, {31'h0, vt[k].e_err});
    end

    // Reset mid-stream while reg 12 still has one write outstanding.
    @(negedge clk);
    we = 1'b0; iv = 1'b0; rr1 = 5'd12; rr2 = 5'd29;
    #2;
    chk("mid.pre_b1", {31'h0, b1}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid.b1", {31'h0, b1}, 32'h0);
    chk("mid.nb_b1", {31'h0, b1_nb}, 32'h0);
    chk("mid.rd1", rd1, 32'h0);
    chk("mid.rd2", rd2, 32'h1FFC);
    chk("mid.err", {30'h0, err, err_nb}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    we = 1'b1; wr = 5'd12; wd = 32'h99;
    #2;
    chk("late.rd1", rd1, 32'h99);
    chk("late.b1", {31'h0, b1}, 32'h0);
    chk("late.err_pre", {31'h0, err}, 32'h0);
    @(negedge clk);
    we = 1'b0;
    #2;
    chk("late.err", {31'h0, err}, 32'h1);
    chk("late.nb_err", {31'h0, err_nb}, 32'h1);
    chk("late.rd1_post", rd1, 32'h99);

    // Random traffic against the reference model, with periodic resets.
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c % 150 == 149) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_reset();
      end
      we  = ($urandom_range(0, 9) < 4);
      wr  = pick();
      wd  = $urandom();
      rr1 = pick();
      rr2 = ($urandom_range(0, 3) == 0) ? rr1 : pick();
      iv  = ($urandom_range(0, 9) < 4);
      ir  = pick();
      #2;
      check_model(c);
      @(posedge clk);
      m_step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipelined_register_file.md
Name: pipelined_register_file

Overview:
Parametrised successor to the pipeline's MIPS register file. It adds three things: configurable data width and depth, write-to-read bypass for the WB->ID hazard, and a per-register in-flight-write scoreboard. Two asynchronous read ports feed the ID stage, and one synchronous write port is driven from WB. Hazard logic uses the Busy outputs to stall ID until a pending destination register has retired.

Parameters:
DATA_WIDTH, 32, bits per register.
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
SP_INDEX, 29, index of the stack pointer.
SP_RESET, 32'h0000_1FFC, reset value of register SP_INDEX; zero-extended/truncated to DATA_WIDTH.
BYPASS_EN, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see the old value.
MAX_INFLIGHT, 3, maximum outstanding writes per register; counter width CW = clog2(MAX_INFLIGHT+1).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
RegWrite  in  1  WB write enable; also retires one scoreboard entry.
WriteRegister  in  ADDR_WIDTH  write / retire index.
WriteData  in  DATA_WIDTH  write data.
ReadRegister1  in  ADDR_WIDTH  read port 1 index.
ReadRegister2  in  ADDR_WIDTH  read port 2 index.
ReadData1  out  DATA_WIDTH  read port 1 data.
ReadData2  out  DATA_WIDTH  read port 2 data.
IssueValid  in  1  an instruction with a register destination leaves ID this cycle.
IssueRegister  in  ADDR_WIDTH  destination index of the issuing instruction.
Busy1  out  1  ReadRegister1 has a pending write not yet visible.
Busy2  out  1  ReadRegister2 has a pending write not yet visible.
ScoreboardError  out  1  sticky flag: overflow or underflow detected.

Behaviour:
- Reset (asynchronous, takes effect immediately, holds while high):
  - all registers 0 except reg[SP_INDEX] = SP_RESET;
  - all counters 0; ScoreboardError 0;
  - Busy1/Busy2 read 0; ReadDataN shows reset contents (SP_RESET when indexing SP_INDEX).
- Register 0:
  - always reads 0;
  - writes to it are discarded;
  - issue and retire targeting it are ignored, never reported as errors;
  - Busy never asserted for it.
- Write: on posedge, if RegWrite and WriteRegister != 0, reg[WriteRegister] <= WriteData.
- Read: combinational, zero latency.
  - ReadDataN = (BYPASS_EN and RegWrite and WriteRegister == ReadRegisterN != 0) ? WriteData : reg[ReadRegisterN].
  - Both ports may select the same index; both return identical data.
- Scoreboard: one CW-bit counter per register, updated on posedge.
  - inc = IssueValid and IssueRegister != 0.
  - dec = RegWrite and WriteRegister != 0.
  - inc and dec on the same index in the same cycle: counter unchanged.
  - inc on a counter at MAX_INFLIGHT: counter unchanged, ScoreboardError <= 1.
  - dec on a counter at 0: counter unchanged, ScoreboardError <= 1.
  - ScoreboardError is cleared only by reset.
- Busy (combinational):
  - BusyN = cnt[ReadRegisterN] != 0, except it reads 0 when BYPASS_EN and dec targets ReadRegisterN and cnt == 1, because the value is being forwarded this cycle.
  - A same-cycle issue to ReadRegisterN does not raise BusyN until the next cycle.
- Reset mid-operation: all in-flight counts are discarded. A late retire after reset counts as underflow and sets ScoreboardError.

Decomposition:
- Shared package rf_pkg holds:
  - REG_ZERO = 0 and REG_SP = 29;
  - default DATA_WIDTH and ADDR_WIDTH;
  - function clog2 for CW.
- One sub-module, register_scoreboard, owns the counter array and the Busy/error logic, parametrised by ADDR_WIDTH, MAX_INFLIGHT and BYPASS_EN.
- Storage and bypass muxes stay in the top module.

Test Plan:
- Reset released, read 29 and 5 -> ReadData1 = 32'h1FFC, ReadData2 = 0, Busy1 = Busy2 = 0, ScoreboardError = 0.
- Write 32'hDEAD_BEEF to reg 0, then read reg 0 -> ReadData1 = 0.
  - Issue to reg 0 -> Busy1 stays 0 and no error.
- Same cycle: RegWrite to reg 8 with 32'h1234, ReadRegister1 = 8.
  - BYPASS_EN = 1 -> ReadData1 = 32'h1234.
  - BYPASS_EN = 0 -> old value, with 32'h1234 visible the next cycle.
- Issue reg 9 twice -> Busy1 = 1 on ReadRegister1 = 9.
  - First retire -> Busy1 still 1.
  - Second retire cycle -> Busy1 = 0 (bypass) and ReadData1 = retire data.
- Issue reg 10 four times with MAX_INFLIGHT = 3 -> ScoreboardError = 1 after the fourth; count stays 3.
  - Retire on reg 11 with count 0 -> error remains 1; only reset clears it.
- Simultaneous issue and retire to reg 12 at count 1 -> count stays 1, Busy stays 1.
  - Reset asserted mid-stream -> all Busy = 0 immediately and reg 12 = 0.
